// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - multi-source interrupt controller with priority, threshold and claim/complete
module irq_ctrl #(
  parameter int NIRQ   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            csr_meie,
  input  logic            cfg_we,
  input  logic [7:2]      cfg_wadr,
  input  logic [31:0]     cfg_wdata,
  input  logic            cfg_re,
  input  logic [7:2]      cfg_radr,
  output logic [31:0]     cfg_rdata,
  output logic            g_interrupt,
  output logic [4:0]      irq_id
);

  localparam logic [5:0] A_ENABLE  = 6'h00;
  localparam logic [5:0] A_EDGE    = 6'h01;
  localparam logic [5:0] A_THRESH  = 6'h02;
  localparam logic [5:0] A_PENDING = 6'h03;
  localparam logic [5:0] A_CLAIM   = 6'h04;
  localparam logic [5:0] A_PRIO0   = 6'h10;

  logic [NIRQ-1:0]   s1_q, s2_q, s3_q;
  logic [NIRQ-1:0]   pend_q, pend_d;
  logic [NIRQ-1:0]   en_q, en_d;
  logic [NIRQ-1:0]   mode_q, mode_d;
  logic [NIRQ-1:0]   isr_q, isr_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [PRIO_W-1:0] prio_q [NIRQ];
  logic [PRIO_W-1:0] prio_d [NIRQ];
  logic [31:0]       rdata_q, rdata_d;
  logic              gint_q;
  logic [4:0]        id_q;

  logic [NIRQ-1:0]   elig, claim_mask, cmp_mask, pend_clr, edge_set;
  logic [PRIO_W-1:0] best_prio;
  logic [4:0]        best_id;
  logic              claim, complete, pend_wr;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  // Descending scan with >= lets the lower ID win a priority tie.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    elig      = pend_q & en_q & ~isr_q;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (elig[i] && (prio_q[i] > thr_q) && (prio_q[i] >= best_prio)) begin
        best_prio = prio_q[i];
        best_id   = 5'(i + 1);
      end
    end
  end

  assign claim    = cfg_re && (cfg_radr == A_CLAIM);
  assign complete = cfg_we && (cfg_wadr == A_CLAIM);
  assign pend_wr  = cfg_we && (cfg_wadr == A_PENDING);

  // Out-of-range or zero complete IDs simply match no source.
  always_comb begin
    claim_mask = '0;
    cmp_mask   = '0;
    for (int i = 0; i < NIRQ; i++) begin
      claim_mask[i] = claim && (best_id == 5'(i + 1));
      cmp_mask[i]   = complete && (cfg_wdata[4:0] == 5'(i + 1));
    end
  end

  assign edge_set = s2_q & ~s3_q;
  assign pend_clr = claim_mask | ({NIRQ{pend_wr}} & cfg_wdata[NIRQ-1:0]);
  // A fresh edge outranks any clear arriving on the same cycle.
  assign pend_d   = (mode_q & ((pend_q & ~pend_clr) | edge_set)) | (~mode_q & s2_q);
  assign isr_d    = (isr_q & ~cmp_mask) | claim_mask;

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    thr_d  = thr_q;
    prio_d = prio_q;
    if (cfg_we) begin
      if (cfg_wadr == A_ENABLE) en_d   = cfg_wdata[NIRQ-1:0];
      if (cfg_wadr == A_EDGE)   mode_d = cfg_wdata[NIRQ-1:0];
      if (cfg_wadr == A_THRESH) thr_d  = cfg_wdata[PRIO_W-1:0];
      for (int i = 0; i < NIRQ; i++) begin
        if (cfg_wadr == A_PRIO0 + 6'(i)) prio_d[i] = cfg_wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      rdata_d = '0;
      case (cfg_radr)
        A_ENABLE:  rdata_d = 32'(en_q);
        A_EDGE:    rdata_d = 32'(mode_q);
        A_THRESH:  rdata_d = 32'(thr_q);
        A_PENDING: rdata_d = 32'(pend_q);
        A_CLAIM:   rdata_d = 32'(best_id);
        default:   ;
      endcase
      for (int i = 0; i < NIRQ; i++) begin
        if (cfg_radr == A_PRIO0 + 6'(i)) rdata_d = 32'(prio_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
      isr_q   <= '0;
      thr_q   <= '0;
      rdata_q <= '0;
      gint_q  <= 1'b0;
      id_q    <= '0;
      for (int i = 0; i < NIRQ; i++) prio_q[i] <= '0;
    end else begin
      s1_q    <= irq_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      isr_q   <= isr_d;
      thr_q   <= thr_d;
      rdata_q <= rdata_d;
      gint_q  <= csr_meie && (best_id != 5'd0);
      id_q    <= best_id;
      prio_q  <= prio_d;
    end
  end

  assign cfg_rdata   = rdata_q;
  assign g_interrupt = gint_q;
  assign irq_id      = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
  localparam int NIRQ   = 8;
  localparam int PRIO_W = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NIRQ-1:0] irq_in = '0;
  logic            csr_meie = 1'b0;
  logic            cfg_we = 1'b0;
  logic [5:0]      cfg_wadr = '0;
  logic [31:0]     cfg_wdata = '0;
  logic            cfg_re = 1'b0;
  logic [5:0]      cfg_radr = '0;
  logic [31:0]     cfg_rdata;
  logic            g_interrupt;
  logic [4:0]      irq_id;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  irq_ctrl #(.NIRQ(NIRQ), .PRIO_W(PRIO_W)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .csr_meie(csr_meie),
    .cfg_we(cfg_we), .cfg_wadr(cfg_wadr), .cfg_wdata(cfg_wdata),
    .cfg_re(cfg_re), .cfg_radr(cfg_radr), .cfg_rdata(cfg_rdata),
    .g_interrupt(g_interrupt), .irq_id(irq_id)
  );

  // All stimulus tasks start and end on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; irq_in = '0; csr_meie = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_wadr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    cfg_re = 1'b1; cfg_radr = a;
    @(negedge clk);
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic pulse(input logic [NIRQ-1:0] m);
    irq_in = m;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL rst_g: got %0b want 0", g_interrupt); end
    n_cmp++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    n_cmp++; if (cfg_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %0h want 0", cfg_rdata); end
    rd(6'h00, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL rst_enable: got %0h want 0", rv); end
  endtask

  task automatic test_single_edge();
    do_reset();
    csr_meie = 1'b1;
    wr(6'h00, 32'h04); wr(6'h01, 32'h04); wr(6'h12, 32'd2); wr(6'h02, 32'd0);
    pulse(8'h04);
    idle(2);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL se_g_early: got %0b want 0", g_interrupt); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b1) begin n_err++; $display("FAIL se_g_on: got %0b want 1", g_interrupt); end
    n_cmp++; if (irq_id !== 5'd3) begin n_err++; $display("FAIL se_id: got %0d want 3", irq_id); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd3) begin n_err++; $display("FAIL se_claim: got %0d want 3", rv); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL se_g_off: got %0b want 0", g_interrupt); end
    n_cmp++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL se_id_off: got %0d want 0", irq_id); end
    rd(6'h03, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL se_pending: got %0h want 0", rv); end
    wr(6'h04, 32'd3);
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL se_g_cmp: got %0b want 0", g_interrupt); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL se_claim_empty: got %0d want 0", rv); end
  endtask

  task automatic test_priority_tie();
    logic [31:0] exp_ids [4] = '{32'd7, 32'd2, 32'd5, 32'd0};
    do_reset();
    csr_meie = 1'b1;
    wr(6'h00, 32'h52); wr(6'h01, 32'h52);
    wr(6'h11, 32'd4); wr(6'h14, 32'd4); wr(6'h16, 32'd6);
    pulse(8'h52);
    idle(4);
    for (int k = 0; k < 4; k++) begin
      rd(6'h04, rv);
      n_cmp++; if (rv !== exp_ids[k]) begin n_err++; $display("FAIL pt_claim%0d: got %0d want %0d", k, rv, exp_ids[k]); end
    end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL pt_g_drained: got %0b want 0", g_interrupt); end
    wr(6'h04, 32'd0); wr(6'h04, 32'd9); wr(6'h04, 32'd3);
    pulse(8'h40);
    idle(4);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL pt_bad_cmp: got %0b want 0", g_interrupt); end
    rd(6'h03, rv);
    n_cmp++; if (rv !== 32'h40) begin n_err++; $display("FAIL pt_pending: got %0h want 40", rv); end
    wr(6'h04, 32'd7);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL pt_cmp_edge: got %0b want 0", g_interrupt); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b1 || irq_id !== 5'd7) begin n_err++; $display("FAIL pt_reassert: got g=%0b id=%0d want g=1 id=7", g_interrupt, irq_id); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd7) begin n_err++; $display("FAIL pt_reclaim: got %0d want 7", rv); end
    wr(6'h04, 32'd2); wr(6'h04, 32'd5); wr(6'h04, 32'd7);
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL pt_empty: got %0d want 0", rv); end
    pulse(8'h12);
    idle(4);
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd2) begin n_err++; $display("FAIL pt_isr2_free: got %0d want 2", rv); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd5) begin n_err++; $display("FAIL pt_isr5_free: got %0d want 5", rv); end
  endtask

  task automatic test_threshold();
    do_reset();
    csr_meie = 1'b1;
    wr(6'h00, 32'h01); wr(6'h10, 32'd3); wr(6'h02, 32'd3);
    irq_in[0] = 1'b1;
    idle(6);
    n_cmp++; if (g_interrupt !== 1'b0 || irq_id !== 5'd0) begin n_err++; $display("FAIL th_blocked: got g=%0b id=%0d want g=0 id=0", g_interrupt, irq_id); end
    wr(6'h02, 32'd2);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL th_wr_edge: got %0b want 0", g_interrupt); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b1 || irq_id !== 5'd1) begin n_err++; $display("FAIL th_open: got g=%0b id=%0d want g=1 id=1", g_interrupt, irq_id); end
    rd(6'h02, rv);
    n_cmp++; if (rv !== 32'd2) begin n_err++; $display("FAIL th_readback: got %0d want 2", rv); end
    wr(6'h18, 32'd7);
    rd(6'h18, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL th_unmapped_prio: got %0h want 0", rv); end
    rd(6'h05, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL th_unmapped: got %0h want 0", rv); end
    irq_in = '0;
  endtask

  task automatic test_level();
    do_reset();
    csr_meie = 1'b1;
    wr(6'h00, 32'h01); wr(6'h10, 32'd1);
    irq_in[0] = 1'b1;
    idle(3);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL lv_early: got %0b want 0", g_interrupt); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b1 || irq_id !== 5'd1) begin n_err++; $display("FAIL lv_on: got g=%0b id=%0d want g=1 id=1", g_interrupt, irq_id); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd1) begin n_err++; $display("FAIL lv_claim: got %0d want 1", rv); end
    idle(4);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL lv_in_service: got %0b want 0", g_interrupt); end
    wr(6'h04, 32'd1);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL lv_cmp_edge: got %0b want 0", g_interrupt); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b1) begin n_err++; $display("FAIL lv_reassert: got %0b want 1", g_interrupt); end
    irq_in[0] = 1'b0;
    idle(3);
    n_cmp++; if (g_interrupt !== 1'b1) begin n_err++; $display("FAIL lv_drop_early: got %0b want 1", g_interrupt); end
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL lv_drop: got %0b want 0", g_interrupt); end
  endtask

  task automatic test_meie_gate();
    do_reset();
    csr_meie = 1'b0;
    wr(6'h00, 32'h01); wr(6'h01, 32'h01); wr(6'h10, 32'd1);
    pulse(8'h01);
    idle(5);
    n_cmp++; if (g_interrupt !== 1'b0 || irq_id !== 5'd1) begin n_err++; $display("FAIL mg_gate: got g=%0b id=%0d want g=0 id=1", g_interrupt, irq_id); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd1) begin n_err++; $display("FAIL mg_claim: got %0d want 1", rv); end
    idle(1);
    n_cmp++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL mg_id_off: got %0d want 0", irq_id); end
  endtask

  task automatic test_edge_during_claim();
    do_reset();
    csr_meie = 1'b1;
    wr(6'h00, 32'h08); wr(6'h01, 32'h08); wr(6'h13, 32'd5);
    pulse(8'h08);
    idle(5);
    n_cmp++; if (g_interrupt !== 1'b1 || irq_id !== 5'd4) begin n_err++; $display("FAIL ec_on: got g=%0b id=%0d want g=1 id=4", g_interrupt, irq_id); end
    irq_in[3] = 1'b1;
    idle(2);
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd4) begin n_err++; $display("FAIL ec_claim: got %0d want 4", rv); end
    rd(6'h03, rv);
    n_cmp++; if (rv !== 32'h08) begin n_err++; $display("FAIL ec_pending_kept: got %0h want 08", rv); end
    n_cmp++; if (g_interrupt !== 1'b0) begin n_err++; $display("FAIL ec_in_service: got %0b want 0", g_interrupt); end
    irq_in[3] = 1'b0;
    wr(6'h04, 32'd4);
    idle(1);
    n_cmp++; if (g_interrupt !== 1'b1) begin n_err++; $display("FAIL ec_reassert: got %0b want 1", g_interrupt); end
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd4) begin n_err++; $display("FAIL ec_second_claim: got %0d want 4", rv); end
    rd(6'h03, rv);
    n_cmp++; if (rv !== 32'h00) begin n_err++; $display("FAIL ec_pending_clr: got %0h want 0", rv); end
    pulse(8'h08);
    idle(4);
    rd(6'h03, rv);
    n_cmp++; if (rv !== 32'h08) begin n_err++; $display("FAIL ec_pending_set: got %0h want 08", rv); end
    wr(6'h03, 32'h08);
    rd(6'h03, rv);
    n_cmp++; if (rv !== 32'h00) begin n_err++; $display("FAIL ec_w1c: got %0h want 0", rv); end
  endtask

  task automatic test_async_reset();
    do_reset();
    csr_meie = 1'b1;
    wr(6'h00, 32'h02); wr(6'h01, 32'h02); wr(6'h11, 32'd7); wr(6'h02, 32'd1);
    pulse(8'h02);
    idle(5);
    rd(6'h04, rv);
    n_cmp++; if (rv !== 32'd2 || g_interrupt !== 1'b1) begin n_err++; $display("FAIL ar_pre: got rdata=%0d g=%0b want rdata=2 g=1", rv, g_interrupt); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (g_interrupt !== 1'b0 || irq_id !== 5'd0 || cfg_rdata !== 32'd0) begin
      n_err++; $display("FAIL ar_immediate: got g=%0b id=%0d rdata=%0h want all 0", g_interrupt, irq_id, cfg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      rd(6'(a), rv);
      n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL ar_reg%0d: got %0h want 0", a, rv); end
    end
    rd(6'h11, rv);
    n_cmp++; if (rv !== 32'd0) begin n_err++; $display("FAIL ar_prio: got %0h want 0", rv); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_edge();
    test_priority_tie();
    test_threshold();
    test_level();
    test_meie_gate();
    test_edge_during_claim();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised multi-source interrupt controller for the RV32I core. It replaces the single-input interrupter with NIRQ sources, each with its own priority, enable and edge/level mode, plus a global threshold and a claim/complete handshake. The block drives `g_interrupt` into ex_stage, gated by `csr_meie`. Its configuration registers sit behind a word-addressed register port decoded from the I/O space.

## Interface
- NIRQ, 8: number of sources, 1..16; source IDs are 1..NIRQ (ID 0 = none).
- PRIO_W, 3: priority width, 1..8; priority 0 = never interrupts.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  NIRQ  raw interrupt lines, asynchronous to clk.
- csr_meie  in  1  machine external interrupt enable from the CSR file.
- cfg_we  in  1  register write strobe.
- cfg_wadr  in  [7:2]  write word address.
- cfg_wdata  in  32  write data.
- cfg_re  in  1  register read strobe.
- cfg_radr  in  [7:2]  read word address.
- cfg_rdata  out  32  read data, registered, valid 1 cycle after cfg_re; reset 0.
- g_interrupt  out  1  interrupt request to the core; registered; reset 0.
- irq_id  out  5  current best claimable ID, registered; reset 0.

## Operation
- Register map (byte offsets):
  - 0x00 ENABLE[NIRQ-1:0], RW.
  - 0x04 EDGE[NIRQ-1:0], RW. 1 = rising-edge source, 0 = level source.
  - 0x08 THRESHOLD[PRIO_W-1:0], RW.
  - 0x0C PENDING, RO. Writing a 1 clears the edge-pending bit for that source.
  - 0x10 CLAIM/COMPLETE.
  - 0x40+4*i PRIO[i] for source ID i+1.
  - Unmapped reads return 0. Unmapped writes are ignored. Unused upper bits read 0.
- Synchroniser: 2 flops per line (s1, s2), plus s3 for edge detection.
- Pending register:
  - Edge source: set on s2 & ~s3; cleared by claim or by a PENDING write-1.
  - Level source: pending <= s2 every cycle.
- In-service register (ISR): the bit for the claimed source is set on claim and cleared on complete.
- A source is eligible when pending & ENABLE & ~ISR & (PRIO > THRESHOLD).
- Arbiter: selects the highest PRIO; on a tie, the lowest ID wins. The result is registered into irq_id (0 if nothing is eligible).
- g_interrupt <= csr_meie & (best_id != 0), using the same-cycle combinational best.
- Claim: cfg_re at 0x10.
  - cfg_rdata <= best ID in that cycle (0 if none).
  - On the same edge: ISR[best] set, and the edge-pending bit for best cleared.
  - A claim that returns 0 has no side effects.
- Complete: cfg_we at 0x10 with wdata[4:0] = ID. Clears ISR[ID].
  - ID 0, ID > NIRQ, or an ID whose ISR bit is clear: ignored, no error.
- A level source that is still asserted after complete becomes eligible again; no extra edge is needed.

## Timing
- irq_in rise to g_interrupt high: 4 clk edges (s1, s2, pending, arbiter/output flop). The source must be enabled, PRIO > THRESHOLD, and csr_meie = 1.
- Claim at edge N: cfg_rdata valid after N. g_interrupt/irq_id reflect the post-claim state after N+1.
- Complete at edge N: the source can reassert g_interrupt after N+1 if still pending.
- Configuration writes (ENABLE, PRIO, THRESHOLD) affect g_interrupt after the next edge.
- Simultaneous events, per edge-pending bit:
  - A new edge in the same cycle as a claim or PENDING clear: the set wins, and the bit stays pending.
  - Claim and complete of the same ID in one cycle cannot occur, because read and write are separate strobes. If both strobes fire for different IDs, both take effect.
- Read of 0x10 while csr_meie = 0 still performs a claim; csr_meie gates only g_interrupt.
- rst_n low, asynchronous, mid-operation: all registers clear immediately, including the synchronisers, ISR, pending and config. Outputs go to 0 without waiting for clk.

## Test plan
- Single edge source: source 3 with PRIO = 2, THRESHOLD = 0, EDGE = 1, ENABLE = 1, meie = 1. Pulse irq_in[2] for 1 cycle → g_interrupt = 1 four edges later, irq_id = 3. Claim reads 3 → g_interrupt = 0 next cycle, PENDING = 0. Complete 3 → stays 0.
- Priority/tie: sources 2 and 5 with PRIO = 4, source 7 with PRIO = 6, all pending. Claims return 7, then 2, then 5, then 0. Complete in any order leaves ISR = 0.
- Threshold: source 1 with PRIO = 3, THRESHOLD = 3 → no interrupt. Write THRESHOLD = 2 → g_interrupt = 1 after 1 edge.
- Level source: irq_in[0] held high. Claim returns 1; while in service, g_interrupt = 0. Complete 1 → g_interrupt = 1 again one edge later. Drop irq_in → g_interrupt = 0 after 4 edges.
- Edge during claim: on an edge source, a second rising edge is aligned with the claim edge → PENDING bit stays 1. A second claim returns the same ID after complete.
- Async reset mid-claim: assert rst_n = 0 between clocks → g_interrupt, irq_id and cfg_rdata = 0 immediately. After release, all registers read 0.
